gerador_nota: RTL and testbench

//  Playback end of the melody note interface: consumes {Freq_in, Temp_in, Disparo_in} from the melody controller.

---
 rtl/nota_pkg.sv | 30 +++
 rtl/gerador_tom.sv | 50 +++++
 rtl/gerador_nota.sv | 119 +++++++++++
 tb/tb_gerador_nota.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nota_pkg.sv
// Shared definitions for the melody note interface: state encoding, default widths and
// the tone periods (in clocks) that the melody controller sends on Freq_in.
package nota_pkg;

  // Playback FSM encoding
  typedef enum logic {
    IDLE = 1'b0,
    TOCA = 1'b1
  } estado_t;

  localparam int unsigned W_DEF  = 28;
  localparam int unsigned CLK_HZ = 50_000_000;

  // Tone period in clocks for a pitch given in Hz; 0 Hz maps to a rest
  function automatic int unsigned periodo(input int unsigned hz);
    return (hz == 0) ? 0 : CLK_HZ / hz;
  endfunction

  // Periods shared with the melody controller (4th octave, equal temperament, rounded Hz)
  localparam int unsigned PER_PAUSA = periodo(0);
  localparam int unsigned PER_DO4   = periodo(262);
  localparam int unsigned PER_RE4   = periodo(294);
  localparam int unsigned PER_MI4   = periodo(330);
  localparam int unsigned PER_FA4   = periodo(349);
  localparam int unsigned PER_SOL4  = periodo(392);
  localparam int unsigned PER_LA4   = periodo(440);
  localparam int unsigned PER_SI4   = periodo(494);
  localparam int unsigned PER_DO5   = periodo(523);

endpackage

// File: rtl/gerador_tom.sv
// Tone divider: free-running period counter c (0..f-1) and registered square wave
// audio = (c < f/2). The registered output always reflects the counter position of the
// current cycle, so the first cycle after clear is already the first high half-period.
module gerador_tom
  import nota_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic         Clk_in,
  input  logic         Rst_in,
  input  logic [W-1:0] f,
  input  logic         enable,
  input  logic         clear,
  output logic         audio
);

  logic [W-1:0] c_q, c_d;
  logic         audio_q, audio_d;

  // Next counter position and the wave level that goes with it
  always_comb begin
    c_d     = '0;
    audio_d = 1'b0;
    if (clear) begin
      c_d     = '0;
      audio_d = (f >> 1) != '0;
    end else if (enable) begin
      if (f < W'(2) || c_q == f - W'(1)) begin
        c_d = '0;
      end else begin
        c_d = c_q + W'(1);
      end
      audio_d = c_d < (f >> 1);
    end
  end

  // Counter and output register, synchronous reset
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      c_q     <= '0;
      audio_q <= 1'b0;
    end else begin
      c_q     <= c_d;
      audio_q <= audio_d;
    end
  end

  assign audio = audio_q;

endmodule

// File: rtl/gerador_nota.sv
// Note playback: latches one note {Freq_in, Temp_in} when idle, plays it for Temp_in
// clocks (0 counts as 1) while Duracao_out is high, then pulses Nota_fim_out in the
// first idle cycle. Stop_in aborts silently.
// Optional NOTA_GAP_EN: silences Audio_out during the last min(GAP_CYCLES, t-1) cycles
// of each note so repeated pitches are separated; timing of the handshake is unchanged.
module gerador_nota
  import nota_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned GAP_CYCLES = 1_000_000
) (
  input  logic         Clk_in,
  input  logic         Rst_in,
  input  logic         Disparo_in,
  input  logic [W-1:0] Freq_in,
  input  logic [W-1:0] Temp_in,
  input  logic         Stop_in,
  output logic         Duracao_out,
  output logic         Audio_out,
  output logic         Nota_fim_out
);

`ifdef NOTA_GAP_EN
  localparam bit GapEn = 1'b1;
`else
  localparam bit GapEn = 1'b0;
`endif
  localparam logic [W-1:0] GapW = W'(GAP_CYCLES);

  estado_t      estado_q, estado_d;
  logic [W-1:0] freq_q, freq_d;
  logic [W-1:0] temp_q, temp_d;
  logic [W-1:0] dur_q, dur_d;
  logic [W-1:0] gap_ini_q, gap_ini_d;
  logic         fim_q, fim_d;
  logic [W-1:0] temp_ini, gap_len;
  logic         load, ultimo, tom_en, tom_audio, em_gap;

  // FSM next state, note latch and duration counter
  always_comb begin
    estado_d  = estado_q;
    freq_d    = freq_q;
    temp_d    = temp_q;
    dur_d     = dur_q;
    gap_ini_d = gap_ini_q;
    fim_d     = 1'b0;
    load      = 1'b0;
    tom_en    = 1'b0;
    temp_ini  = (Temp_in == '0) ? W'(1) : Temp_in;
    gap_len   = (GapW < temp_ini - W'(1)) ? GapW : temp_ini - W'(1);
    ultimo    = dur_q == temp_q - W'(1);
    if (Stop_in) begin
      // Abort wins over load and normal completion: no end pulse
      estado_d = IDLE;
      dur_d    = '0;
    end else begin
      case (estado_q)
        IDLE: begin
          if (Disparo_in) begin
            load      = 1'b1;
            freq_d    = Freq_in;
            temp_d    = temp_ini;
            gap_ini_d = temp_ini - gap_len;
            dur_d     = '0;
            estado_d  = TOCA;
          end
        end
        TOCA: begin
          if (ultimo) begin
            estado_d = IDLE;
            dur_d    = '0;
            fim_d    = 1'b1;
          end else begin
            dur_d  = dur_q + W'(1);
            tom_en = 1'b1;
          end
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  // State and latch registers, synchronous active-high reset
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      estado_q  <= IDLE;
      freq_q    <= '0;
      temp_q    <= '0;
      dur_q     <= '0;
      gap_ini_q <= '0;
      fim_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      freq_q    <= freq_d;
      temp_q    <= temp_d;
      dur_q     <= dur_d;
      gap_ini_q <= gap_ini_d;
      fim_q     <= fim_d;
    end
  end

  // freq_d carries Freq_in on the load edge so the first half-period starts immediately
  gerador_tom #(
    .W (W)
  ) u_tom (
    .Clk_in (Clk_in),
    .Rst_in (Rst_in),
    .f      (freq_d),
    .enable (tom_en),
    .clear  (load),
    .audio  (tom_audio)
  );

  assign em_gap       = GapEn && (estado_q == TOCA) && (dur_q >= gap_ini_q);
  assign Audio_out    = tom_audio && !em_gap;
  assign Duracao_out  = estado_q == TOCA;
  assign Nota_fim_out = fim_q;

endmodule

// File: tb/tb_gerador_nota.sv
// Bench for gerador_nota: a driver issues notes and queues the expected note record; a
// monitor consumes records as notes appear on Duracao_out and checks length, end pulse
// and the audio waveform cycle by cycle. Builds with or without NOTA_GAP_EN.
module tb_gerador_nota;

  localparam int unsigned W   = 28;
  localparam int unsigned GAP = 8;

  logic         Clk_in = 1'b0;
  logic         Rst_in = 1'b1;
  logic         Disparo_in = 1'b0;
  logic         Stop_in = 1'b0;
  logic [W-1:0] Freq_in = '0;
  logic [W-1:0] Temp_in = '0;
  logic         Duracao_out, Audio_out, Nota_fim_out;

  gerador_nota #(
    .W          (W),
    .GAP_CYCLES (GAP)
  ) dut (
    .Clk_in       (Clk_in),
    .Rst_in       (Rst_in),
    .Disparo_in   (Disparo_in),
    .Freq_in      (Freq_in),
    .Temp_in      (Temp_in),
    .Stop_in      (Stop_in),
    .Duracao_out  (Duracao_out),
    .Audio_out    (Audio_out),
    .Nota_fim_out (Nota_fim_out)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct {
    int len;
    bit fim;
    int f;
    int gs;
  } nota_t;

  nota_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  task automatic check(input string nome, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nome, got, want, $time);
    end
  endtask

  // Reference: what a note should look like, straight from the note rules
  function automatic nota_t modelo(input int f, input int t, input int stop_at);
    nota_t n;
    int    tt;
    tt    = (t == 0) ? 1 : t;
    n.f   = f;
    n.len = (stop_at > 0) ? stop_at : tt;
    n.fim = (stop_at == 0);
`ifdef NOTA_GAP_EN
    n.gs  = tt - ((int'(GAP) < tt - 1) ? int'(GAP) : tt - 1);
`else
    n.gs  = tt;
`endif
    return n;
  endfunction

  function automatic bit som(input nota_t n, input int k);
    return (n.f >= 2) && ((k % n.f) < (n.f / 2)) && (k < n.gs);
  endfunction

  // Monitor
  bit    mon_en = 1'b0;
  bit    in_note = 1'b0;
  int    k = 0;
  int    aud_err = 0;
  int    fim_espurio = 0;
  int    aud_idle = 0;
  nota_t cur;

  always @(negedge Clk_in) begin
    if (mon_en) begin
      if (Duracao_out) begin
        if (!in_note) begin
          in_note = 1'b1;
          k       = 0;
          aud_err = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_note", 1, 0);
            cur = '{len: 0, fim: 1'b0, f: 0, gs: 0};
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (Audio_out != som(cur, k)) aud_err++;
        if (Nota_fim_out) fim_espurio++;
        k++;
      end else begin
        if (in_note) begin
          in_note = 1'b0;
          check("note_length", k, cur.len);
          check("nota_fim_pulse", int'(Nota_fim_out), int'(cur.fim));
          check("audio_waveform_errors", aud_err, 0);
        end else if (Nota_fim_out) begin
          fim_espurio++;
        end
        if (Audio_out) aud_idle++;
      end
    end
  end

  // Issue one note from a negedge while idle; returns at the negedge of the first idle
  // cycle after it, so a following call loads back-to-back.
  task automatic tocar(input int f, input int t, input int stop_at, input bit hold);
    Freq_in    = W'(f);
    Temp_in    = W'(t);
    Disparo_in = 1'b1;
    exp_q.push_back(modelo(f, t, stop_at));
    @(negedge Clk_in);
    Disparo_in = hold;
    Freq_in    = W'($urandom);
    Temp_in    = W'($urandom);
    if (stop_at > 0) begin
      repeat (stop_at - 1) @(negedge Clk_in);
      Stop_in = 1'b1;
      @(negedge Clk_in);
      Stop_in = 1'b0;
    end else begin
      repeat ((t == 0) ? 1 : t) @(negedge Clk_in);
    end
  endtask

  initial begin
    int  f, t, tt, s;
    bit  hold, prev_hold;

    // Reset with a note already requested: all outputs must stay low
    Rst_in     = 1'b1;
    Disparo_in = 1'b1;
    Freq_in    = W'(10);
    Temp_in    = W'(40);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk_in);
      check("reset_duracao", int'(Duracao_out), 0);
      check("reset_audio", int'(Audio_out), 0);
      check("reset_nota_fim", int'(Nota_fim_out), 0);
    end
    Rst_in = 1'b0;
    mon_en = 1'b1;

    // First load on the edge after reset drops: 10-clock period, 40 clocks
    tocar(10, 40, 0, 1'b0);
    repeat (3) @(negedge Clk_in);

    // Back-to-back with Disparo_in held, new duration presented in the end-pulse cycle
    tocar(10, 20, 0, 1'b1);
    tocar(7, 30, 0, 1'b0);
    repeat (2) @(negedge Clk_in);

    // Rests and zero duration
    tocar(0, 16, 0, 1'b0);
    tocar(1, 16, 0, 1'b0);
    @(negedge Clk_in);
    tocar(5, 0, 0, 1'b0);
    repeat (2) @(negedge Clk_in);

    // Abort at clock 7 of a 40-clock note
    tocar(6, 40, 7, 1'b0);
    check("stop_idle_duracao", int'(Duracao_out), 0);
    check("stop_idle_audio", int'(Audio_out), 0);

    // Stop held with a request pending: no note may start
    Stop_in    = 1'b1;
    Disparo_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk_in);
      check("stop_hold_duracao", int'(Duracao_out), 0);
    end
    Stop_in    = 1'b0;
    Disparo_in = 1'b0;
    repeat (2) @(negedge Clk_in);

    // Articulation gap cases (plain tone in the default build)
    tocar(4, 32, 0, 1'b0);
    tocar(4, 5, 0, 1'b0);
    @(negedge Clk_in);

    // Randomized notes
    prev_hold = 1'b0;
    for (int n = 0; n < 40; n++) begin
      f  = int'($urandom_range(0, 20));
      t  = int'($urandom_range(0, 50));
      tt = (t == 0) ? 1 : t;
      s  = 0;
      if ($urandom_range(0, 4) == 0 && tt >= 2) s = int'($urandom_range(1, tt - 1));
      hold = (s == 0) && (n != 39) && ($urandom_range(0, 1) == 1);
      if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge Clk_in);
      tocar(f, t, s, hold);
      prev_hold = hold;
    end

    repeat (5) @(negedge Clk_in);
    check("pending_notes", exp_q.size(), 0);
    check("note_still_running", int'(in_note), 0);
    check("spurious_nota_fim", fim_espurio, 0);
    check("audio_while_idle", aud_idle, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
